// File: rtl/ram_nr1w.sv
// Multi-read, single-write word RAM with a power-up clear sweep, range checking
// and optional 32-bit half-word fetch ports.

module ram_nr1w_rport #(
  parameter int          DW    = 64,
  parameter int          DEPTH = 4096,
  parameter logic [63:0] BASE  = 64'h0000_0000_8000_0000,
  parameter bit          HALF  = 1'b0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     run_i,
  input  logic                     rd_en_i,
  input  logic [63:0]              rd_addr_i,
  output logic [$clog2(DEPTH)-1:0] rd_idx_o,
  input  logic [DW-1:0]            rd_word_i,
  input  logic                     wr_go_i,
  input  logic [$clog2(DEPTH)-1:0] wr_idx_i,
  input  logic [DW-1:0]            wr_data_i,
  input  logic [DW/8-1:0]          wr_strb_i,
  output logic [DW-1:0]            rd_data_o,
  output logic                     rd_valid_o,
  output logic                     rd_err_o
);
  localparam int AW  = $clog2(DEPTH);
  localparam int OFF = $clog2(DW/8);
  localparam int NB  = DW/8;

  logic [63:0]   off, idx64, w64;
  logic          inr;
  logic [DW-1:0] merged, resp_d;
  logic [31:0]   hsel;
  logic [DW-1:0] rd_data_q;
  logic          rd_valid_q, rd_err_q;

  // Underflow below BASE yields a huge index, so one compare covers both bounds.
  assign off      = rd_addr_i - BASE;
  assign idx64    = off >> OFF;
  assign inr      = (rd_addr_i >= BASE) && (idx64 < 64'(DEPTH));
  assign rd_idx_o = idx64[AW-1:0];

  // Write-first bypass when the write hits the word being read this cycle.
  always_comb begin
    merged = rd_word_i;
    if (wr_go_i && (wr_idx_i == rd_idx_o)) begin
      for (int b = 0; b < NB; b++)
        if (wr_strb_i[b]) merged[8*b +: 8] = wr_data_i[8*b +: 8];
    end
  end

  assign w64  = 64'(merged);
  assign hsel = rd_addr_i[2] ? w64[63:32] : w64[31:0];

  always_comb begin
    resp_d = '0;
    if (inr) resp_d = HALF ? DW'({32'b0, hsel}) : merged;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      rd_err_q   <= 1'b0;
    end else if (run_i && rd_en_i) begin
      rd_data_q  <= resp_d;
      rd_valid_q <= 1'b1;
      rd_err_q   <= !inr;
    end else begin
      rd_valid_q <= 1'b0;
      rd_err_q   <= 1'b0;
    end
  end

  assign rd_data_o  = rd_data_q;
  assign rd_valid_o = rd_valid_q;
  assign rd_err_o   = rd_err_q;
endmodule

module ram_nr1w #(
  parameter int          NR        = 2,
  parameter int          DW        = 64,
  parameter int          DEPTH     = 4096,
  parameter logic [63:0] BASE      = 64'h0000_0000_8000_0000,
  parameter logic [NR-1:0] HALF_MASK = NR'(1)
) (
  input  logic             clk,
  input  logic             reset,
  output logic             ready,
  input  logic [NR-1:0]    rd_en,
  input  logic [NR*64-1:0] rd_addr,
  output logic [NR*DW-1:0] rd_data,
  output logic [NR-1:0]    rd_valid,
  output logic [NR-1:0]    rd_err,
  input  logic             wr_en,
  input  logic [63:0]      wr_addr,
  input  logic [DW-1:0]    wr_data,
  input  logic [DW/8-1:0]  wr_strb,
  output logic             wr_err
);
  localparam int AW  = $clog2(DEPTH);
  localparam int OFF = $clog2(DW/8);
  localparam int NB  = DW/8;

  typedef enum logic {CLEAR, RUN} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] clr_cnt_q, clr_cnt_d;
  logic          run;
  logic          wr_err_q;

  logic [DW-1:0] mem_q [DEPTH];

  logic [63:0]   wr_off, wr_idx64;
  logic          wr_inr, wr_go;
  logic [AW-1:0] wr_idx;

  logic [NR-1:0][AW-1:0] ridx;
  logic [NR-1:0][DW-1:0] rword;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= CLEAR;
      clr_cnt_q <= '0;
      wr_err_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      wr_err_q  <= run && wr_en && !wr_inr;
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    case (state_q)
      CLEAR: begin
        clr_cnt_d = clr_cnt_q + 1'b1;
        if (clr_cnt_q == AW'(DEPTH-1)) state_d = RUN;
      end
      RUN:     state_d = RUN;
      default: state_d = CLEAR;
    endcase
  end

  assign run    = (state_q == RUN);
  assign ready  = run;
  assign wr_err = wr_err_q;

  assign wr_off   = wr_addr - BASE;
  assign wr_idx64 = wr_off >> OFF;
  assign wr_inr   = (wr_addr >= BASE) && (wr_idx64 < 64'(DEPTH));
  assign wr_idx   = wr_idx64[AW-1:0];
  assign wr_go    = run && wr_en && wr_inr;

  // Storage has no reset; the CLEAR sweep zeroes it one word per cycle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (!run) begin
        mem_q[clr_cnt_q] <= '0;
      end else if (wr_go) begin
        for (int b = 0; b < NB; b++)
          if (wr_strb[b]) mem_q[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end

  for (genvar i = 0; i < NR; i++) begin : g_rp
    assign rword[i] = mem_q[ridx[i]];

    ram_nr1w_rport #(
      .DW    (DW),
      .DEPTH (DEPTH),
      .BASE  (BASE),
      .HALF  (HALF_MASK[i] && (DW == 64))
    ) u_rp (
      .clk        (clk),
      .reset      (reset),
      .run_i      (run),
      .rd_en_i    (rd_en[i]),
      .rd_addr_i  (rd_addr[64*i +: 64]),
      .rd_idx_o   (ridx[i]),
      .rd_word_i  (rword[i]),
      .wr_go_i    (wr_go),
      .wr_idx_i   (wr_idx),
      .wr_data_i  (wr_data),
      .wr_strb_i  (wr_strb),
      .rd_data_o  (rd_data[DW*i +: DW]),
      .rd_valid_o (rd_valid[i]),
      .rd_err_o   (rd_err[i])
    );
  end
endmodule

// File: tb/tb_ram_nr1w.sv
// Directed plus random bench for ram_nr1w (DEPTH=16, DW=64, NR=2, port 0 half-width)
// against a word-array reference model.

module tb_ram_nr1w;
  localparam logic [63:0] BASE = 64'h0000_0000_8000_0000;

  logic         clk = 1'b0;
  logic         reset;
  logic         ready;
  logic [1:0]   rd_en;
  logic [127:0] rd_addr;
  logic [127:0] rd_data;
  logic [1:0]   rd_valid, rd_err;
  logic         wr_en;
  logic [63:0]  wr_addr, wr_data;
  logic [7:0]   wr_strb;
  logic         wr_err;

  int checks   = 0;
  int failures = 0;

  logic [63:0] mdl  [16];
  logic [63:0] last [2];

  ram_nr1w #(.NR(2), .DW(64), .DEPTH(16), .BASE(BASE), .HALF_MASK(2'b01)) dut (
    .clk(clk), .reset(reset), .ready(ready),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .rd_valid(rd_valid), .rd_err(rd_err),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_strb(wr_strb), .wr_err(wr_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // 16 words of 8 bytes starting at BASE
  function automatic bit in_rng(input logic [63:0] a);
    return (a >= BASE) && ((a - BASE) < 64'd128);
  endfunction

  function automatic int widx(input logic [63:0] a);
    return int'((a - BASE) / 8);
  endfunction

  task automatic model_clear();
    for (int k = 0; k < 16; k++) mdl[k] = '0;
    last[0] = '0;
    last[1] = '0;
  endtask

  task automatic cyc(input string tag, input logic [1:0] re, input logic [63:0] a0,
                     input logic [63:0] a1, input logic we, input logic [63:0] wa,
                     input logic [63:0] wd, input logic [7:0] st, input bit run);
    logic [63:0] a [2];
    logic [63:0] w, ed [2];
    logic        ev [2], ee [2], ewe;
    a[0] = a0; a[1] = a1;
    ewe = run && we && !in_rng(wa);
    if (run && we && in_rng(wa))
      for (int b = 0; b < 8; b++)
        if (st[b]) mdl[widx(wa)][8*b +: 8] = wd[8*b +: 8];
    for (int p = 0; p < 2; p++) begin
      ev[p] = run && re[p];
      ee[p] = ev[p] && !in_rng(a[p]);
      if (ev[p]) begin
        if (ee[p]) ed[p] = '0;
        else begin
          w = mdl[widx(a[p])];
          if (p == 0) ed[p] = {32'b0, (a[p][2] ? w[63:32] : w[31:0])};
          else        ed[p] = w;
        end
        last[p] = ed[p];
      end else ed[p] = last[p];
    end
    rd_en = re; rd_addr = {a1, a0};
    wr_en = we; wr_addr = wa; wr_data = wd; wr_strb = st;
    tick();
    chk({tag, ".v0"}, 64'(rd_valid[0]), 64'(ev[0]));
    chk({tag, ".v1"}, 64'(rd_valid[1]), 64'(ev[1]));
    chk({tag, ".d0"}, rd_data[63:0], ed[0]);
    chk({tag, ".d1"}, rd_data[127:64], ed[1]);
    if (ev[0]) chk({tag, ".e0"}, 64'(rd_err[0]), 64'(ee[0]));
    if (ev[1]) chk({tag, ".e1"}, 64'(rd_err[1]), 64'(ee[1]));
    chk({tag, ".werr"}, 64'(wr_err), 64'(ewe));
  endtask

  function automatic logic [63:0] rnd_addr();
    case ($urandom_range(0, 9))
      0:       return BASE - 64'(8 * $urandom_range(1, 4));
      1:       return BASE + 64'd128 + 64'($urandom_range(0, 63));
      default: return BASE + 64'($urandom_range(0, 127));
    endcase
  endfunction

  task automatic idle_rd(input string tag);
    cyc(tag, 2'b00, BASE, BASE, 1'b0, BASE, '0, '0, 1'b1);
  endtask

  task automatic clear_phase(input string tag);
    for (int k = 0; k < 16; k++) begin
      cyc({tag, ".clr"}, 2'b11, rnd_addr(), rnd_addr(), 1'b1, rnd_addr(),
          {$urandom, $urandom}, 8'hFF, 1'b0);
      chk({tag, ".ready"}, 64'(ready), 64'(k == 15));
    end
  endtask

  initial begin
    logic [63:0] a0, a1, wa;
    reset = 1'b1; rd_en = '0; rd_addr = '0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0; wr_strb = '0;
    tick(); tick();
    chk("rst.ready", 64'(ready), 64'd0);
    chk("rst.valid", 64'(rd_valid), 64'd0);
    chk("rst.data0", rd_data[63:0], 64'd0);
    chk("rst.data1", rd_data[127:64], 64'd0);
    chk("rst.werr", 64'(wr_err), 64'd0);
    model_clear();

    reset = 1'b0;
    clear_phase("boot");

    // zeroed after clear
    cyc("r33", 2'b10, BASE, 64'h8000_0040, 1'b0, BASE, '0, '0, 1'b1);
    chk("r33.const", rd_data[127:64], 64'd0);

    cyc("r34w", 2'b00, BASE, BASE, 1'b1, 64'h8000_0008, 64'h1122334455667788, 8'h0F, 1'b1);
    cyc("r34r", 2'b10, BASE, 64'h8000_0008, 1'b0, BASE, '0, '0, 1'b1);
    chk("r34.const", rd_data[127:64], 64'h0000_0000_5566_7788);

    cyc("r35", 2'b10, BASE, 64'h8000_0010, 1'b1, 64'h8000_0010, 64'hAAAA_AAAA_AAAA_AAAA, 8'hFF, 1'b1);
    chk("r35.const", rd_data[127:64], 64'hAAAA_AAAA_AAAA_AAAA);

    cyc("r36w", 2'b00, BASE, BASE, 1'b1, 64'h8000_0008, 64'hDEAD_BEEF_CAFE_F00D, 8'hFF, 1'b1);
    cyc("r36hi", 2'b01, 64'h8000_000C, BASE, 1'b0, BASE, '0, '0, 1'b1);
    chk("r36hi.const", rd_data[63:0], 64'h0000_0000_DEAD_BEEF);
    cyc("r36lo", 2'b01, 64'h8000_0008, BASE, 1'b0, BASE, '0, '0, 1'b1);
    chk("r36lo.const", rd_data[63:0], 64'h0000_0000_CAFE_F00D);
    idle_rd("hold");

    // both ports same index, same cycle
    cyc("same", 2'b11, 64'h8000_0008, 64'h8000_0008, 1'b0, BASE, '0, '0, 1'b1);

    cyc("r37", 2'b10, BASE, 64'h7FFF_FFF8, 1'b1, 64'h8000_0080, 64'h5555_5555_5555_5555, 8'hFF, 1'b1);
    chk("r37.err", 64'(rd_err[1]), 64'd1);
    chk("r37.data", rd_data[127:64], 64'd0);
    chk("r37.werr", 64'(wr_err), 64'd1);
    idle_rd("r37.after");
    for (int k = 0; k < 16; k++)
      cyc("r37.scan", 2'b10, BASE, BASE + 64'(8 * k), 1'b0, BASE, '0, '0, 1'b1);

    for (int n = 0; n < 300; n++) begin
      a0 = rnd_addr();
      a1 = rnd_addr();
      wa = ($urandom_range(0, 2) == 0) ? a1 : rnd_addr();
      cyc("rand", 2'($urandom_range(0, 3)), a0, a1, 1'($urandom_range(0, 1)), wa,
          {$urandom, $urandom}, 8'($urandom_range(0, 255)), 1'b1);
    end

    // reset mid-RUN with a read in flight, then reset again at clear cycle 7
    rd_en = 2'b11; reset = 1'b1;
    tick();
    chk("rr.valid", 64'(rd_valid), 64'd0);
    chk("rr.ready", 64'(ready), 64'd0);
    model_clear();
    reset = 1'b0;
    for (int k = 0; k < 7; k++)
      cyc("r38.pre", 2'b11, rnd_addr(), rnd_addr(), 1'b1, rnd_addr(), {$urandom, $urandom}, 8'hFF, 1'b0);
    reset = 1'b1;
    tick();
    chk("r38.rst", 64'(ready), 64'd0);
    reset = 1'b0;
    clear_phase("r38");
    for (int k = 0; k < 16; k++)
      cyc("r38.scan", 2'b11, BASE + 64'(8 * k + 4), BASE + 64'(8 * k), 1'b0, BASE, '0, '0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/ram_nr1w.md
RAM_NR1W -- requirements
Module: ram_nr1w

Interface
REQ-001 SHALL provide parameter NR, default 2, number of independent read ports (1..4).
REQ-002 SHALL provide parameter DW, default 64, data width in bits (32 or 64).
REQ-003 SHALL provide parameter DEPTH, default 4096, number of DW-bit words (power of two, >=16).
REQ-004 SHALL provide parameter BASE, default 64'h0000_0000_8000_0000, byte address of word 0.
REQ-005 SHALL provide parameter HALF_MASK, default NR'b01, where bit i set makes read port i a 32-bit fetch port (only legal when DW=64).
REQ-006 SHALL have port clk, input, 1: the single clock, all state updates on its rising edge.
REQ-007 SHALL have port reset, input, 1: synchronous reset, active-high.
REQ-008 SHALL have port ready, output, 1: memory is initialised and accepting requests.
REQ-009 SHALL have port rd_en, input, NR: per-port read request.
REQ-010 SHALL have port rd_addr, input, NR*64: per-port byte address, port i at bits [64i+63:64i].
REQ-011 SHALL have port rd_data, output, NR*DW: per-port read data, port i at bits [DWi+DW-1:DWi].
REQ-012 SHALL have port rd_valid, output, NR: per-port response valid.
REQ-013 SHALL have port rd_err, output, NR: per-port out-of-range flag, qualified by rd_valid.
REQ-014 SHALL have ports wr_en (input, 1), wr_addr (input, 64), wr_data (input, DW) and wr_strb (input, DW/8): write request, byte address, data and byte-lane enables.
REQ-015 SHALL have port wr_err, output, 1: pulses when a write was dropped as out-of-range.

Function
REQ-016 SHALL compute the word index as (addr - BASE) >> log2(DW/8), ignoring the low offset bits.
REQ-017 SHALL treat an address as in-range iff addr >= BASE and index < DEPTH.
REQ-018 SHALL implement a two-state FSM, CLEAR and RUN, entering CLEAR on reset.
REQ-019 In CLEAR, SHALL write zero to word clr_cnt each cycle, clr_cnt counting 0..DEPTH-1, then enter RUN on the cycle after writing word DEPTH-1 (CLEAR lasts exactly DEPTH cycles).
REQ-020 SHALL drive ready=1 only in RUN.
REQ-021 In CLEAR, SHALL ignore rd_en and wr_en: no rd_valid, no wr_err, no memory update other than the clear.
REQ-022 In RUN, SHALL answer a read sampled with rd_en[i]=1 in cycle N with rd_valid[i]=1 and rd_data in cycle N+1 (fixed 1-cycle latency, no backpressure).
REQ-023 SHALL hold rd_valid[i]=0 and rd_data[i] at its previous value in cycles following rd_en[i]=0.
REQ-024 For an out-of-range read, SHALL return rd_valid=1, rd_err=1 and rd_data=0 in cycle N+1.
REQ-025 In RUN, SHALL update only the byte lanes of the addressed word whose wr_strb bit is 1 at the clock edge where wr_en=1 and the address is in range.
REQ-026 SHALL drop an out-of-range write and pulse wr_err=1 for exactly the following cycle.
REQ-027 When a read and a write target the same index in the same cycle, SHALL return write-first data: strobed lanes from wr_data, other lanes from the old word.
REQ-028 SHALL allow any number of read ports to read the same index in the same cycle, with identical data returned on each.
REQ-029 For a port with HALF_MASK[i]=1, SHALL return {32'b0, addr[2] ? word[63:32] : word[31:0]}, using addr[2] registered with the request.
REQ-030 SHALL wrap nothing: index arithmetic is 64-bit, so addresses below BASE underflow to large values and SHALL be flagged out-of-range.

Reset
REQ-031 While reset=1 at an edge, SHALL set ready=0, rd_valid=0, rd_err=0, rd_data=0, wr_err=0, clr_cnt=0 and state=CLEAR.
REQ-032 SHALL restart the full DEPTH-cycle clear when reset is asserted mid-CLEAR or mid-RUN; in-flight read responses are discarded.

Verification (DEPTH=16, DW=64, NR=2, HALF_MASK=2'b01)
REQ-033 Reset release -> ready=0 for 16 cycles, then 1; a read of 0x8000_0040 returns 0.
REQ-034 Write 0x8000_0008, data 0x1122334455667788, strb 0x0F, then port 1 reads it -> rd_data=0x0000000055667788, rd_valid one cycle after rd_en.
REQ-035 Same-cycle write of 0x8000_0010, data 0xAAAA..., strb 0xFF, with port 1 reading 0x8000_0010 -> port 1 returns 0xAAAAAAAAAAAAAAAA.
REQ-036 Port 0 (half) reads 0x8000_000C after word 1 = 0xDEADBEEF_CAFEF00D -> rd_data=0x00000000DEADBEEF; a read of 0x8000_0008 -> 0x00000000CAFEF00D.
REQ-037 Read of 0x7FFF_FFF8 and a write to 0x8000_0080 -> rd_err=1 and rd_data=0; wr_err pulses for one cycle; memory is unchanged.
REQ-038 Reset asserted at clear cycle 7 -> ready stays 0 for 16 full cycles after release.
